// File: rtl/uart16550_rx_poller.sv
`timescale 1ns/1ps
// uart16550_rx_poller
// Wishbone master that drives a UART16550 (8-bit data-bus mode) without
// firmware. After reset it programs LCR/DLL/DLM/LCR/FCR, then loops polling
// the LSR and draining the RBR into a small local FIFO. The FIFO drains
// through a valid/ready byte interface. LSR error bits are kept as sticky flags.
//
// Ports
//   wb_clk_i, wb_rst_n_i        : clock, asynchronous active-low reset
//   wb_adr_o/dat_o/sel_o/cyc_o/stb_o/we_o, wb_dat_i/ack_i : Wishbone master
//   rx_data_o, rx_valid_o, rx_ready_i : received-byte stream (FIFO head)
//   init_done_o                 : register programming finished
//   overrun_o, parity_err_o, frame_err_o : sticky LSR bits 1/2/3
//   clr_err_i                   : clears the sticky flags (a coincident set wins)
module uart16550_rx_poller #(
    parameter logic [15:0] DIVISOR  = 16'h001B,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  FCR_VAL  = 8'h07,
    parameter int          DEPTH    = 4,
    parameter int          POLL_GAP = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        init_done_o,
    output logic        overrun_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    input  logic        clr_err_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        W_LCR1, W_DLL, W_DLM, W_LCR2, W_FCR, R_LSR, R_RBR, GAP
    } state_t;

    state_t           state;
    logic             cyc;
    logic [4:0]       adr;
    logic [7:0]       dat;
    logic             we;
    logic [GAP_W-1:0] gap_cnt;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [4:0]       nxt_adr;
    logic [7:0]       nxt_dat;
    logic             nxt_we;
    logic             xfer_done;
    logic             push;
    logic             pop;
    logic             lsr_ack;
    logic             fifo_full;
    logic             unused_dat_hi;

    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;
    assign wb_adr_o = adr;
    assign wb_dat_o = {24'h0, dat};
    assign wb_we_o  = we;
    assign wb_sel_o = 4'b0001;

    // Only the low byte of the UART read data carries information.
    assign unused_dat_hi = ^wb_dat_i[31:8];

    // An ack is only meaningful while our own cycle is open.
    assign xfer_done = cyc && wb_ack_i;
    assign push      = xfer_done && (state == R_RBR);
    assign lsr_ack   = xfer_done && (state == R_LSR);
    assign fifo_full = (count == DEPTH_C);

    assign rx_valid_o = (count != '0);
    assign pop        = rx_valid_o && rx_ready_i;
    // Gate the head byte so the output reads 0 whenever the FIFO is empty,
    // including immediately after an asynchronous reset.
    assign rx_data_o  = rx_valid_o ? mem[rd_ptr] : 8'h00;

    // Address / data / direction of the transfer the current state issues.
    always_comb begin
        nxt_adr = 5'd0;
        nxt_dat = 8'h00;
        nxt_we  = 1'b0;
        case (state)
            W_LCR1:  begin nxt_adr = 5'd3; nxt_dat = 8'h83;         nxt_we = 1'b1; end
            W_DLL:   begin nxt_adr = 5'd0; nxt_dat = DIVISOR[7:0];  nxt_we = 1'b1; end
            W_DLM:   begin nxt_adr = 5'd1; nxt_dat = DIVISOR[15:8]; nxt_we = 1'b1; end
            W_LCR2:  begin nxt_adr = 5'd3; nxt_dat = LCR_VAL;       nxt_we = 1'b1; end
            W_FCR:   begin nxt_adr = 5'd2; nxt_dat = FCR_VAL;       nxt_we = 1'b1; end
            R_LSR:   nxt_adr = 5'd5;
            default: nxt_adr = 5'd0;
        endcase
    end

    // Sequencer. A transfer opens on the first edge seen with cyc low in a
    // transfer state and closes on the ack edge, so every transfer is
    // followed by at least one idle cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= W_LCR1;
            cyc         <= 1'b0;
            adr         <= 5'd0;
            dat         <= 8'h00;
            we          <= 1'b0;
            gap_cnt     <= '0;
            init_done_o <= 1'b0;
        end else if (cyc) begin
            if (wb_ack_i) begin
                cyc <= 1'b0;
                adr <= 5'd0;
                dat <= 8'h00;
                we  <= 1'b0;
                case (state)
                    W_LCR1: state <= W_DLL;
                    W_DLL:  state <= W_DLM;
                    W_DLM:  state <= W_LCR2;
                    W_LCR2: state <= W_FCR;
                    W_FCR: begin
                        state       <= R_LSR;
                        init_done_o <= 1'b1;
                    end
                    R_LSR: begin
                        gap_cnt <= '0;
                        // The slot check guarantees the RBR read always has room.
                        if (wb_dat_i[0] && (count < DEPTH_C)) state <= R_RBR;
                        else                                  state <= GAP;
                    end
                    default: state <= R_LSR;
                endcase
            end
        end else if (state == GAP) begin
            if (gap_cnt == GAP_LAST) begin
                gap_cnt <= '0;
                // Keep idling while full; polling would only find no room.
                if (!fifo_full) state <= R_LSR;
            end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end else begin
            cyc <= 1'b1;
            adr <= nxt_adr;
            dat <= nxt_dat;
            we  <= nxt_we;
        end
    end

    // FIFO storage holds data only; occupancy is tracked by the pointers/count.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= wb_dat_i[7:0];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: a set arriving with a clear takes priority.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            overrun_o    <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else if (clr_err_i) begin
            overrun_o    <= lsr_ack && wb_dat_i[1];
            parity_err_o <= lsr_ack && wb_dat_i[2];
            frame_err_o  <= lsr_ack && wb_dat_i[3];
        end else begin
            overrun_o    <= overrun_o    | (lsr_ack && wb_dat_i[1]);
            parity_err_o <= parity_err_o | (lsr_ack && wb_dat_i[2]);
            frame_err_o  <= frame_err_o  | (lsr_ack && wb_dat_i[3]);
        end
    end

endmodule

// File: tb/tb_uart16550_rx_poller.sv
`timescale 1ns/1ps
module tb_uart16550_rx_poller;

    localparam int DEPTH    = 4;
    localparam int POLL_GAP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        init_done, overrun, parity_err, frame_err;
    logic        clr_err = 1'b0;

    int errors = 0;
    int checks = 0;

    // Bench UART model state
    logic [7:0]  uart_q[$];
    logic [7:0]  exp_q[$];
    logic [12:0] wr_log[$];
    logic [12:0] exp_wr[5] = '{{5'd3, 8'h83}, {5'd0, 8'h1B}, {5'd1, 8'h00},
                               {5'd3, 8'h03}, {5'd2, 8'h07}};
    int   ack_dly = 0;
    int   wait_cnt = 0;
    int   rbr_reads = 0;
    int   valid_cycles = 0;
    logic fe = 1'b0;
    logic oe = 1'b0;
    logic hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic ended_prev = 1'b0;

    always #5 clk = ~clk;

    uart16550_rx_poller #(
        .DIVISOR(16'h001B), .LCR_VAL(8'h03), .FCR_VAL(8'h07),
        .DEPTH(DEPTH), .POLL_GAP(POLL_GAP)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_we_o(wb_we), .wb_ack_i(wb_ack),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .init_done_o(init_done), .overrun_o(overrun),
        .parity_err_o(parity_err), .frame_err_o(frame_err),
        .clr_err_i(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Slave: ack after ack_dly wait cycles; combinational so 0 gives zero-wait.
    assign wb_ack = wb_cyc && (wait_cnt == ack_dly);

    always @(posedge clk) begin
        if (wb_cyc && !wb_ack) wait_cnt <= wait_cnt + 1;
        else                   wait_cnt <= 0;
        if (wb_cyc && wb_ack) begin
            if (wb_we) wr_log.push_back({wb_adr, wb_dat_o[7:0]});
            else if (wb_adr == 5'd0 && uart_q.size() > 0) begin
                void'(uart_q.pop_front());
                rbr_reads++;
            end
        end
    end

    // Read data is refreshed mid-cycle so it is stable at the sampling edge.
    always @(negedge clk) begin
        if (wb_adr == 5'd5)
            wb_dat_i = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, fe, 1'b0, oe, (uart_q.size() > 0)};
        else if (wb_adr == 5'd0 && uart_q.size() > 0)
            wb_dat_i = {24'h0, uart_q[0]};
        else
            wb_dat_i = 32'h0;
    end

    // Output monitors: scoreboard pop, head stability, idle cycle after transfer.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) chk("rx_extra_byte", 0, 1);
            else                   chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
        if (rx_valid) valid_cycles++;
        if (hold_prev && rx_valid) chk("rx_hold", {24'h0, rx_data}, {24'h0, prev_data});
        hold_prev = rx_valid && !rx_ready;
        prev_data = rx_data;
        if (ended_prev) chk("idle_gap", {31'h0, wb_cyc}, 0);
        ended_prev = wb_cyc && wb_ack;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_cyc"}, {31'h0, wb_cyc}, 0);
        chk({tag, "_stb"}, {31'h0, wb_stb}, 0);
        chk({tag, "_we"}, {31'h0, wb_we}, 0);
        chk({tag, "_adr"}, {27'h0, wb_adr}, 0);
        chk({tag, "_dat"}, wb_dat_o, 0);
        chk({tag, "_sel"}, {28'h0, wb_sel}, 1);
        chk({tag, "_valid"}, {31'h0, rx_valid}, 0);
        chk({tag, "_data"}, {24'h0, rx_data}, 0);
        chk({tag, "_init"}, {31'h0, init_done}, 0);
        chk({tag, "_flags"}, {29'h0, overrun, parity_err, frame_err}, 0);
    endtask

    task automatic run_init(input string tag);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_first_cyc"}, {31'h0, wb_cyc}, 1);
        chk({tag, "_first_adr"}, {27'h0, wb_adr}, 3);
        chk({tag, "_first_dat"}, wb_dat_o, 32'h83);
        chk({tag, "_first_we"}, {31'h0, wb_we}, 1);
        n = 0;
        while (!(wb_cyc && wb_ack && wb_we && wb_adr == 5'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_fcr_seen"}, {31'h0, n < 200}, 1);
        chk({tag, "_init_before"}, {31'h0, init_done}, 0);
        @(negedge clk);
        chk({tag, "_init_after"}, {31'h0, init_done}, 1);
        chk({tag, "_nwrites"}, wr_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk({tag, "_write"}, {19'h0, (i < wr_log.size()) ? wr_log[i] : 13'h1FFF},
                {19'h0, exp_wr[i]});
        chk({tag, "_valid"}, {31'h0, rx_valid}, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        uart_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic set_ack_dly(input int d);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (wb_cyc && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        ack_dly = d;
    endtask

    task automatic wait_flag_frame(input string tag);
        int n;
        n = 0;
        while (!frame_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'h0, frame_err}, 1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int r0;
        logic [4:0]  c_adr;
        logic [31:0] c_dat;
        logic        c_we;

        // Reset state
        repeat (3) @(negedge clk);
        chk_outs_zero("reset");

        // Init sequence
        run_init("init");

        // Two bytes streamed straight through
        rx_ready = 1'b1;
        valid_cycles = 0;
        send_byte(8'h55);
        send_byte(8'hA3);
        wait_drain("stream_drain");
        repeat (10) @(negedge clk);
        chk("stream_valid_cycles", valid_cycles, 2);
        chk("stream_flags", {29'h0, overrun, parity_err, frame_err}, 0);

        // FIFO fills, RBR reads stop, then drains in order
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        r0 = rbr_reads;
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        repeat (200) @(negedge clk);
        chk("full_rbr_reads", rbr_reads - r0, DEPTH);
        chk("full_uart_left", uart_q.size(), 2);
        chk("full_valid", {31'h0, rx_valid}, 1);
        chk("full_head", {24'h0, rx_data}, 32'h01);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        wait_drain("full_drain");

        // Sticky error flags
        @(posedge clk);
        #1;
        fe = 1'b1;
        oe = 1'b1;
        wait_flag_frame("err_frame_set");
        chk("err_overrun_set", {31'h0, overrun}, 1);
        chk("err_parity_clear", {31'h0, parity_err}, 0);
        @(posedge clk);
        #1;
        fe = 1'b0;
        oe = 1'b0;
        repeat (30) @(negedge clk);
        chk("err_frame_sticky", {31'h0, frame_err}, 1);
        pulse_clr();
        chk("err_frame_cleared", {31'h0, frame_err}, 0);
        chk("err_overrun_cleared", {31'h0, overrun}, 0);

        // Clear coincident with an LSR ack that carries a framing error
        @(posedge clk);
        #1;
        fe = 1'b1;
        wait_flag_frame("err_frame_reset2");
        n = 0;
        while (!(wb_cyc && wb_ack && wb_adr == 5'd5 && !wb_we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("err_lsr_seen", {31'h0, n < 100}, 1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        fe = 1'b0;
        @(negedge clk);
        chk("err_set_wins", {31'h0, frame_err}, 1);
        pulse_clr();
        chk("err_frame_cleared2", {31'h0, frame_err}, 0);

        // Slow slave: request must hold for all six cycles
        set_ack_dly(5);
        n = 0;
        while (!wb_cyc && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("slow_cyc_seen", {31'h0, wb_cyc}, 1);
        c_adr = wb_adr;
        c_dat = wb_dat_o;
        c_we  = wb_we;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("slow_adr", {27'h0, wb_adr}, {27'h0, c_adr});
            chk("slow_dat", wb_dat_o, c_dat);
            chk("slow_we", {31'h0, wb_we}, {31'h0, c_we});
            chk("slow_stb", {31'h0, wb_stb}, 1);
        end
        @(negedge clk);
        chk("slow_release", {31'h0, wb_cyc}, 0);
        ack_dly = 0;

        // Reset in the middle of an RBR read with two bytes queued
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        set_ack_dly(3);
        r0 = rbr_reads;
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        n = 0;
        while (!(rbr_reads - r0 >= 2 && wb_cyc && wb_adr == 5'd0 && !wb_we) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rbr_seen", {31'h0, n < 400}, 1);
        chk("mid_queued", {31'h0, rx_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs_zero("rst_async");
        uart_q.delete();
        exp_q.delete();
        wr_log.delete();
        ack_dly = 0;
        repeat (2) @(negedge clk);
        chk_outs_zero("rst_hold");
        run_init("reinit");

        // Traffic resumes after the restart
        rx_ready = 1'b1;
        send_byte(8'h3C);
        wait_drain("reinit_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
